// File: rtl/block_unpadding.sv
// rtl/block_unpadding.sv - serializes 64-bit Ascon blocks MSB-byte-first, dropping the final block's padding
module block_unpadding (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        blk_valid_i,
    output logic        blk_ready_o,
    input  logic [63:0] blk_data_i,
    input  logic        blk_last_i,
    input  logic [2:0]  blk_nbytes_i,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic [7:0]  byte_data_o,
    output logic        byte_last_o,
    output logic        done_o
);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] shift_q, shift_d;
    logic [3:0]  rem_q, rem_d;
    logic        last_q, last_d;
    logic        done_q, done_d;

    logic        in_drain;
    logic        blk_hs;
    logic        byte_hs;
    logic [3:0]  load_cnt;

    // Outputs are gated by rst_i so nothing is offered in the reset cycle itself.
    assign in_drain     = (state_q == DRAIN);
    assign blk_ready_o  = !in_drain && !rst_i;
    assign byte_valid_o = in_drain && !rst_i;
    assign byte_data_o  = byte_valid_o ? shift_q[63:56] : 8'h00;
    assign byte_last_o  = byte_valid_o && last_q && (rem_q == 4'd1);
    assign done_o       = done_q && !rst_i;

    assign blk_hs   = blk_valid_i && blk_ready_o;
    assign byte_hs  = byte_valid_o && byte_ready_i;
    assign load_cnt = blk_last_i ? {1'b0, blk_nbytes_i} : 4'd8;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (blk_hs) begin
                    shift_d = blk_data_i;
                    last_d  = blk_last_i;
                    rem_d   = load_cnt;
                    // An empty final block carries only padding: finish without draining.
                    if (load_cnt == 4'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (byte_hs) begin
                    shift_d = {shift_q[55:0], 8'h00};
                    rem_d   = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = IDLE;
                        done_d  = last_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shift_q <= 64'd0;
            rem_q   <= 4'd0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_block_unpadding.sv
// tb/tb_block_unpadding.sv - randomized self-checking bench for block_unpadding
module tb_block_unpadding;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        blk_valid_i = 1'b0;
    logic        blk_ready_o;
    logic [63:0] blk_data_i = 64'd0;
    logic        blk_last_i = 1'b0;
    logic [2:0]  blk_nbytes_i = 3'd0;
    logic        byte_valid_o;
    logic        byte_ready_i = 1'b1;
    logic [7:0]  byte_data_o;
    logic        byte_last_o;
    logic        done_o;

    block_unpadding dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .blk_valid_i  (blk_valid_i),
        .blk_ready_o  (blk_ready_o),
        .blk_data_i   (blk_data_i),
        .blk_last_i   (blk_last_i),
        .blk_nbytes_i (blk_nbytes_i),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .byte_data_o  (byte_data_o),
        .byte_last_o  (byte_last_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;

    logic [7:0]  obs_b[$];
    bit          obs_l[$];
    int          obs_c[$];
    int          done_c[$];
    int          acc_c[$];
    int          rise_c[$];

    logic [63:0] msg_data[$];
    bit          msg_last[$];
    int          msg_nb[$];

    logic [7:0]  exp_b[$];
    bit          exp_l[$];
    int          exp_done;

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_last = 1'b0;
    logic        prev_blk_ready = 1'b0;
    logic [7:0]  prev_data = 8'd0;

    always @(negedge clk) begin
        cyc++;
        if (rst_i) begin
            checks++;
            if (byte_valid_o !== 1'b0 || done_o !== 1'b0 || blk_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: valid=%b done=%b blk_ready=%b, required 0 0 0",
                         byte_valid_o, done_o, blk_ready_o);
            end
        end else begin
            if (prev_valid && !prev_ready) begin
                checks++;
                if (byte_valid_o !== 1'b1 || byte_data_o !== prev_data || byte_last_o !== prev_last) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%h last=%b, required 1 %h %b",
                             byte_valid_o, byte_data_o, byte_last_o, prev_data, prev_last);
                end
            end
            checks++;
            if (blk_ready_o && byte_valid_o) begin
                errors++;
                $display("FAIL ready_in_drain: blk_ready=%b while byte_valid=%b, required 0", blk_ready_o, byte_valid_o);
            end
            if (byte_valid_o && byte_ready_i) begin
                obs_b.push_back(byte_data_o);
                obs_l.push_back(byte_last_o);
                obs_c.push_back(cyc);
            end
            if (blk_valid_i && blk_ready_o) acc_c.push_back(cyc);
            if (done_o) done_c.push_back(cyc);
            if (blk_ready_o && !prev_blk_ready) rise_c.push_back(cyc);
        end
        prev_valid     = byte_valid_o;
        prev_ready     = byte_ready_i;
        prev_data      = byte_data_o;
        prev_last      = byte_last_o;
        prev_blk_ready = blk_ready_o;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) byte_ready_i = 1'b1;
            else if (ready_mode == 1) byte_ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        obs_b.delete(); obs_l.delete(); obs_c.delete();
        done_c.delete(); acc_c.delete(); rise_c.delete();
        msg_data.delete(); msg_last.delete(); msg_nb.delete();
    endtask

    task automatic push_blk(input logic [63:0] d, input bit l, input int nb);
        msg_data.push_back(d);
        msg_last.push_back(l);
        msg_nb.push_back(nb);
    endtask

    // Reference: each block contributes its leading n bytes, n = 8 or nbytes for the final block.
    task automatic build_expected();
        logic [63:0] tmp;
        int n;
        exp_b.delete();
        exp_l.delete();
        exp_done = 0;
        foreach (msg_data[k]) begin
            n = msg_last[k] ? msg_nb[k] : 8;
            for (int i = 0; i < n; i++) begin
                tmp = msg_data[k] >> (56 - 8 * i);
                exp_b.push_back(tmp[7:0]);
                exp_l.push_back(msg_last[k] && (i == n - 1));
            end
            if (msg_last[k]) exp_done = 1;
        end
    endtask

    task automatic drive_msg(input bit hold_valid, output bit ok);
        bit got;
        int w;
        ok = 1'b1;
        for (int i = 0; i < msg_data.size(); i++) begin
            blk_valid_i  = 1'b1;
            blk_data_i   = msg_data[i];
            blk_last_i   = msg_last[i];
            blk_nbytes_i = 3'(msg_nb[i]);
            got = 1'b0;
            w = 0;
            while (!got && w < 200) begin
                @(negedge clk);
                got = blk_ready_o;
                w++;
            end
            @(posedge clk);
            #1;
            if (!got) begin
                ok = 1'b0;
                blk_valid_i = 1'b0;
                return;
            end
            if (!hold_valid && i < msg_data.size() - 1) begin
                blk_valid_i = 1'b0;
                blk_data_i  = 64'($urandom) << 32 | 64'($urandom);
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        blk_valid_i = 1'b0;
    endtask

    task automatic wait_drained(output bit ok);
        int w;
        w = 0;
        ok = 1'b0;
        while (w < 400) begin
            @(negedge clk);
            w++;
            if (blk_ready_o && !byte_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (byte_data_o !== 8'h00 || byte_last_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: data=%h last=%b, required 00 0", byte_data_o, byte_last_o);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (blk_ready_o !== 1'b1 || byte_valid_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: blk_ready=%b valid=%b done=%b, required 1 0 0",
                     blk_ready_o, byte_valid_o, done_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_full();
        bit ok1, ok2;
        clear_all();
        push_blk(64'h0123456789ABCDEF, 1'b0, 0);
        build_expected();
        drive_msg(1'b1, ok1);
        wait_drained(ok2);
        checks++;
        if (!ok1 || !ok2 || obs_b.size() != 8 || acc_c.size() != 1) begin
            errors++;
            $display("FAIL single_full_count: ok=%b%b bytes=%0d accepts=%0d, required 11 8 1",
                     ok1, ok2, obs_b.size(), acc_c.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_b[i] !== exp_b[i] || obs_l[i] !== 1'b0 || obs_c[i] != acc_c[0] + 1 + i) begin
                    errors++;
                    $display("FAIL single_full_byte%0d: data=%h last=%b cyc=%0d, required %h 0 %0d",
                             i, obs_b[i], obs_l[i], obs_c[i], exp_b[i], acc_c[0] + 1 + i);
                end
            end
            checks++;
            if (rise_c.size() != 1 || rise_c[0] != acc_c[0] + 9) begin
                errors++;
                $display("FAIL single_full_ready: rises=%0d first=%0d, required 1 at %0d",
                         rise_c.size(), (rise_c.size() > 0) ? rise_c[0] : -1, acc_c[0] + 9);
            end
        end
        checks++;
        if (done_c.size() != 0) begin
            errors++;
            $display("FAIL single_full_done: pulses=%0d, required 0", done_c.size());
        end
    endtask

    task automatic test_short_final();
        bit ok1, ok2;
        clear_all();
        push_blk(64'hAABBCC8000000000, 1'b1, 3);
        build_expected();
        drive_msg(1'b1, ok1);
        wait_drained(ok2);
        checks++;
        if (!ok1 || !ok2 || obs_b.size() != 3) begin
            errors++;
            $display("FAIL short_final_count: ok=%b%b bytes=%0d, required 11 3", ok1, ok2, obs_b.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_b[i] !== exp_b[i] || obs_l[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL short_final_byte%0d: data=%h last=%b, required %h %b",
                             i, obs_b[i], obs_l[i], exp_b[i], exp_l[i]);
                end
            end
            checks++;
            if (done_c.size() != 1 || done_c[0] != obs_c[2] + 1) begin
                errors++;
                $display("FAIL short_final_done: pulses=%0d first=%0d, required 1 at %0d",
                         done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, obs_c[2] + 1);
            end
        end
    endtask

    task automatic test_empty_final();
        bit ok1, ok2;
        clear_all();
        push_blk(64'h8000000000000000, 1'b1, 0);
        drive_msg(1'b1, ok1);
        wait_drained(ok2);
        checks++;
        if (!ok1 || !ok2 || obs_b.size() != 0 || acc_c.size() != 1) begin
            errors++;
            $display("FAIL empty_final_bytes: ok=%b%b bytes=%0d accepts=%0d, required 11 0 1",
                     ok1, ok2, obs_b.size(), acc_c.size());
        end else begin
            checks++;
            if (done_c.size() != 1 || done_c[0] != acc_c[0] + 1) begin
                errors++;
                $display("FAIL empty_final_done: pulses=%0d first=%0d, required 1 at %0d",
                         done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, acc_c[0] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok1, ok2;
        clear_all();
        push_blk(64'h1122334455667788, 1'b0, 0);
        build_expected();
        ready_mode = 2;
        drive_msg(1'b1, ok1);
        for (int j = 0; j < 16; j++) begin
            byte_ready_i = 1'(j % 2);
            tick();
        end
        ready_mode = 0;
        byte_ready_i = 1'b1;
        wait_drained(ok2);
        checks++;
        if (!ok1 || !ok2 || obs_b.size() != 8 || acc_c.size() != 1) begin
            errors++;
            $display("FAIL backpressure_count: ok=%b%b bytes=%0d, required 11 8", ok1, ok2, obs_b.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_b[i] !== exp_b[i] || obs_c[i] != acc_c[0] + 2 + 2 * i) begin
                    errors++;
                    $display("FAIL backpressure_byte%0d: data=%h cyc=%0d, required %h %0d",
                             i, obs_b[i], obs_c[i], exp_b[i], acc_c[0] + 2 + 2 * i);
                end
            end
        end
    endtask

    task automatic test_multi_block();
        bit ok1, ok2;
        clear_all();
        push_blk({$urandom, $urandom}, 1'b0, 0);
        push_blk({$urandom, $urandom}, 1'b0, 0);
        push_blk({$urandom, $urandom}, 1'b1, 5);
        build_expected();
        drive_msg(1'b1, ok1);
        wait_drained(ok2);
        checks++;
        if (!ok1 || !ok2 || obs_b.size() != 21 || acc_c.size() != 3) begin
            errors++;
            $display("FAIL multi_block_count: ok=%b%b bytes=%0d accepts=%0d, required 11 21 3",
                     ok1, ok2, obs_b.size(), acc_c.size());
        end else begin
            for (int i = 0; i < 21; i++) begin
                checks++;
                if (obs_b[i] !== exp_b[i] || obs_l[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL multi_block_byte%0d: data=%h last=%b, required %h %b",
                             i, obs_b[i], obs_l[i], exp_b[i], exp_l[i]);
                end
            end
            checks++;
            if (acc_c[1] != acc_c[0] + 9 || acc_c[2] != acc_c[1] + 9) begin
                errors++;
                $display("FAIL multi_block_period: accepts=%0d,%0d,%0d, required period 9",
                         acc_c[0], acc_c[1], acc_c[2]);
            end
            checks++;
            if (done_c.size() != 1 || done_c[0] != obs_c[20] + 1) begin
                errors++;
                $display("FAIL multi_block_done: pulses=%0d, required 1 at %0d", done_c.size(), obs_c[20] + 1);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        bit ok1, ok2;
        int w;
        clear_all();
        push_blk({$urandom, $urandom}, 1'b1, 0);
        msg_last[0] = 1'b0;
        drive_msg(1'b1, ok1);
        w = 0;
        while (obs_b.size() < 4 && w < 100) begin
            tick();
            w++;
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        repeat (4) tick();
        checks++;
        if (!ok1 || obs_b.size() != 4 || done_c.size() != 0 || byte_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drain: ok=%b bytes=%0d done=%0d valid=%b, required 1 4 0 0",
                     ok1, obs_b.size(), done_c.size(), byte_valid_o);
        end
        clear_all();
        push_blk({$urandom, $urandom}, 1'b1, 2);
        build_expected();
        drive_msg(1'b1, ok1);
        wait_drained(ok2);
        checks++;
        if (!ok1 || !ok2 || obs_b.size() != 2 || done_c.size() != 1) begin
            errors++;
            $display("FAIL post_reset_msg: ok=%b%b bytes=%0d done=%0d, required 11 2 1",
                     ok1, ok2, obs_b.size(), done_c.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_b[i] !== exp_b[i] || obs_l[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL post_reset_byte%0d: data=%h last=%b, required %h %b",
                             i, obs_b[i], obs_l[i], exp_b[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit ok1, ok2;
        int nblk;
        ready_mode = 1;
        for (int m = 0; m < 25; m++) begin
            clear_all();
            nblk = $urandom_range(1, 4);
            for (int k = 0; k < nblk; k++) begin
                push_blk({$urandom, $urandom}, (k == nblk - 1), (k == nblk - 1) ? $urandom_range(0, 7) : 0);
            end
            build_expected();
            drive_msg(1'($urandom_range(0, 1)), ok1);
            wait_drained(ok2);
            checks++;
            if (!ok1 || !ok2 || obs_b.size() != exp_b.size() || done_c.size() != exp_done) begin
                errors++;
                $display("FAIL random_msg%0d: ok=%b%b bytes=%0d done=%0d, required 11 %0d %0d",
                         m, ok1, ok2, obs_b.size(), done_c.size(), exp_b.size(), exp_done);
            end else begin
                for (int i = 0; i < exp_b.size(); i++) begin
                    checks++;
                    if (obs_b[i] !== exp_b[i] || obs_l[i] !== exp_l[i]) begin
                        errors++;
                        $display("FAIL random_msg%0d_byte%0d: data=%h last=%b, required %h %b",
                                 m, i, obs_b[i], obs_l[i], exp_b[i], exp_l[i]);
                    end
                end
            end
        end
        ready_mode = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_full();
        test_short_final();
        test_empty_final();
        test_backpressure();
        test_multi_block();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_unpadding.md
# block_unpadding

Byte-stream de-packer for the Ascon datapath. It is the output-side counterpart of block padding: it accepts 64-bit blocks from the permutation/XOR stage and serializes them MSB-byte-first onto a byte stream. On the final block it emits only the valid message bytes and discards the `0x80 00..` padding region. It sits between the Ascon core's plaintext/ciphertext block output and the subsystem's byte-wide output interface.

## Interface
Parameters:
- None. Block width is fixed at `BLOCK_WIDTH` = 64 from `ascon_pack`, i.e. 8 bytes per block.

Ports:
- `clk_i` in 1: single clock; all logic rising-edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `blk_valid_i` in 1: input block valid.
- `blk_ready_o` out 1: block accepted when `blk_valid_i && blk_ready_o`.
- `blk_data_i` in 64: block data; byte 0 = bits [63:56].
- `blk_last_i` in 1: block is the final block of the message.
- `blk_nbytes_i` in 3: number of valid bytes in the final block, 0..7. Ignored when `blk_last_i` = 0.
- `byte_valid_o` out 1: output byte valid.
- `byte_ready_i` in 1: downstream ready.
- `byte_data_o` out 8: output byte.
- `byte_last_o` out 1: marks the last message byte.
- `done_o` out 1: one-cycle pulse when the message is fully drained.

## Operation
- State: `IDLE`, `DRAIN`. Registers:
  - `shift_q` [63:0]
  - `rem_q` [3:0], bytes remaining, 0..8
  - `last_q`
  - `done_q`
- `IDLE`:
  - `blk_ready_o` = 1, except while `rst_i` = 1.
  - On block handshake: `shift_q` <= `blk_data_i`; `last_q` <= `blk_last_i`; `rem_q` <= `blk_last_i ? blk_nbytes_i : 8`.
  - If the loaded count is 0 (last block, `nbytes` = 0): stay in `IDLE` and set `done_q` for one cycle.
  - Otherwise go to `DRAIN`.
- `DRAIN`:
  - `blk_ready_o` = 0; `blk_valid_i` is ignored and upstream holds its block.
  - `byte_valid_o` = 1; `byte_data_o` = `shift_q[63:56]`; `byte_last_o` = `last_q && rem_q == 1`.
  - On byte handshake: `shift_q` <= `shift_q << 8`; `rem_q` <= `rem_q - 1`.
  - If `rem_q` was 1: go to `IDLE`, and set `done_q` if `last_q`.
- Output stability: while `byte_valid_o && !byte_ready_i`, `byte_data_o` and `byte_last_o` hold unchanged. `byte_valid_o` never drops without a handshake, except on reset.
- Padding region handling: bytes `nbytes`..7 of the final block are never emitted, whatever their content. No padding check is performed.
- A last block with `nbytes` = 0 corresponds to the empty padded block that follows a full final block. It produces no bytes, only `done_o`. `byte_last_o` was never asserted for that message; a block with `nbytes` = 0 never asserts `byte_last_o`.
- Reset values: state `IDLE`, `shift_q` = 0, `rem_q` = 0, `last_q` = 0, `done_q` = 0.
  - Outputs: `byte_valid_o` = 0, `byte_data_o` = 0x00, `byte_last_o` = 0, `done_o` = 0.
  - `blk_ready_o` = 0 while `rst_i` is high, and 1 from the first cycle after release.
- Reset mid-drain: remaining bytes are discarded and no `done_o` is produced. The next accepted block starts fresh.

## Timing
- Block accepted at edge N → `byte_valid_o` = 1 from cycle N+1. No combinational path from `blk_*` inputs to `byte_*` outputs.
- With `byte_ready_i` held at 1:
  - A full block drains in cycles N+1..N+8.
  - `blk_ready_o` returns high in cycle N+9.
  - Block period is 9 cycles, i.e. one bubble per block.
- Final-block timing:
  - Final byte handshake at edge M → `done_o` = 1 in cycle M+1 only, concurrently with `blk_ready_o` = 1.
  - Empty last block accepted at edge N → `done_o` = 1 in cycle N+1 only.
- `blk_ready_o` depends on state only (and `rst_i`), never on `blk_valid_i` or `byte_ready_i`.
- Each stall cycle on `byte_ready_i` adds exactly one cycle of latency.

## Test plan
- **Single full block.** Input: one block, `blk_last_i` = 0, data 0x0123456789ABCDEF, `byte_ready_i` = 1. Required: bytes 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles; `byte_last_o` always 0; no `done_o`; `blk_ready_o` high 9 cycles after accept.
- **Short final block.** Input: last block, `nbytes` = 3, data 0xAABBCC8000000000. Required: bytes AA,BB,CC only; `byte_last_o` with CC; `done_o` one-cycle pulse the cycle after the CC handshake; 0x80 never appears.
- **Empty final block.** Input: last block, `nbytes` = 0, data 0x8000000000000000. Required: `byte_valid_o` stays 0; `done_o` pulses exactly one cycle, the cycle after accept.
- **Backpressure.** Input: full block 0x1122334455667788 with `byte_ready_i` toggling 0,1,0,1,…. Required: each byte held stable while not ready; order 11..88 preserved; drain takes 16 cycles.
- **Multi-block message.** Input: full, full, then last with `nbytes` = 5, with `blk_valid_i` held high throughout. Required: 21 bytes in order; `blk_ready_o` low during every drain; `byte_last_o` only on byte 21; a single `done_o`.
- **Reset mid-drain.** Input: assert `rst_i` for 1 cycle after 4 of 8 bytes. Required: `byte_valid_o` = 0 and `done_o` = 0 during and after reset; a following last block with `nbytes` = 2 emits exactly 2 bytes, then `done_o`.
